// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction-cycle control FSM. Issues the instruction read,
//            latches the instruction register, waits for the execute stage,
//            then pulses the PC increment (or branch-load) for the next
//            instruction. This is the only block that advances the PC.
// Ports    : clk, reset        - clock / synchronous active-high reset
//            run_i             - permits leaving IDLE / continuing after ADVANCE
//            mem_ack_i         - instruction memory data valid
//            mem_rdata_i       - instruction word (valid with mem_ack_i)
//            exec_done_i       - execute stage finished current instruction
//            branch_taken_i    - sampled with exec_done_i (branch build only)
//            mem_rd_o          - read request, high throughout FETCH
//            ir_o              - instruction register
//            ir_valid_o        - one-cycle pulse in DECODE
//            pc_en_o           - one-cycle PC increment pulse
//            pc_load_o         - one-cycle PC branch-load pulse
//            halted_o, fault_o - sticky terminal-state indicators
//            state_o           - current state encoding (debug)
// Config   : FETCH_SEQ_BRANCH_EN - when defined, branch_taken_i is captured
//            in EXEC and ADVANCE pulses pc_load_o instead of pc_en_o.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int         IW          = 16,
  parameter logic [3:0] HALT_OP     = 4'hF,
  parameter int         MEM_TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run_i,
  input  logic          mem_ack_i,
  input  logic [IW-1:0] mem_rdata_i,
  input  logic          exec_done_i,
  input  logic          branch_taken_i,
  output logic          mem_rd_o,
  output logic [IW-1:0] ir_o,
  output logic          ir_valid_o,
  output logic          pc_en_o,
  output logic          pc_load_o,
  output logic          halted_o,
  output logic          fault_o,
  output logic [2:0]    state_o
);

  // Wide enough to hold MEM_TIMEOUT-1 for any MEM_TIMEOUT >= 1.
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_ADVANCE = 3'd4,
    S_HALT    = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;
  logic          w_flag_next;

`ifdef FETCH_SEQ_BRANCH_EN
  assign w_flag_next = branch_taken_i;
`else
  // Port kept for a uniform interface; the flag stays 0 in this build.
  assign w_flag_next = branch_taken_i & 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        // An ack on the final allowed cycle takes priority over the timeout.
        if (mem_ack_i) begin
          ir_d    = mem_rdata_i;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        if (ir_q[IW-1:IW-4] == HALT_OP) state_d = S_HALT;
        else                            state_d = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done_i) begin
          flag_d  = w_flag_next;
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        // run is only consulted here, so an in-flight instruction always completes.
        if (run_i) state_d = S_FETCH;
        else       state_d = S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;  // encoding 7 is illegal
    endcase
  end

  // Moore outputs decoded from the registered state.
  assign mem_rd_o   = (state_q == S_FETCH);
  assign ir_valid_o = (state_q == S_DECODE);
  assign pc_en_o    = (state_q == S_ADVANCE) & ~flag_q;
  assign pc_load_o  = (state_q == S_ADVANCE) &  flag_q;
  assign halted_o   = (state_q == S_HALT);
  assign fault_o    = (state_q == S_FAULT);
  assign state_o    = state_q;
  assign ir_o       = ir_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed self-checking bench for fetch_sequencer with
//            hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_i;
  logic        mem_ack_i;
  logic [15:0] mem_rdata_i;
  logic        exec_done_i;
  logic        branch_taken_i;
  logic        mem_rd_o;
  logic [15:0] ir_o;
  logic        ir_valid_o;
  logic        pc_en_o;
  logic        pc_load_o;
  logic        halted_o;
  logic        fault_o;
  logic [2:0]  state_o;

  int errors = 0;
  int checks = 0;

  fetch_sequencer #(
    .IW          (16),
    .HALT_OP     (4'hF),
    .MEM_TIMEOUT (8)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .run_i          (run_i),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i),
    .exec_done_i    (exec_done_i),
    .branch_taken_i (branch_taken_i),
    .mem_rd_o       (mem_rd_o),
    .ir_o           (ir_o),
    .ir_valid_o     (ir_valid_o),
    .pc_en_o        (pc_en_o),
    .pc_load_o      (pc_load_o),
    .halted_o       (halted_o),
    .fault_o        (fault_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {mem_rd_o, ir_valid_o, pc_en_o, pc_load_o, halted_o, fault_o};
  endfunction

  task automatic do_reset();
    reset          = 1'b1;
    run_i          = 1'b0;
    mem_ack_i      = 1'b0;
    mem_rdata_i    = 16'h0000;
    exec_done_i    = 1'b0;
    branch_taken_i = 1'b0;
    step();
    reset = 1'b0;
  endtask

  int pc_pulses;

  initial begin
    // ---------------- reset state ----------------
    mem_rdata_i = 16'hAAAA;
    do_reset();
    step();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_ir", 32'(ir_o), 32'h0);
    check("rst_outs", 32'(outs()), 32'h0);

    // ---------------- 1: back-to-back instructions ----------------
    mem_rdata_i = 16'h1234; mem_ack_i = 1'b1; exec_done_i = 1'b1; run_i = 1'b1;
    pc_pulses = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("t1_state_%0d", c), 32'(state_o), 32'((c % 4) + 1));
      check($sformatf("t1_pcen_%0d", c), 32'(pc_en_o), 32'((c % 4) == 3));
      if (c % 4 >= 1) check($sformatf("t1_ir_%0d", c), 32'(ir_o), 32'h1234);
      if (pc_en_o) pc_pulses++;
    end
    check("t1_pc_pulses", 32'(pc_pulses), 32'd2);
    run_i = 1'b0; mem_ack_i = 1'b0; exec_done_i = 1'b0;
    step();
    check("t1_idle", 32'(state_o), 32'd0);
    check("t1_ir_hold", 32'(ir_o), 32'h1234);

    // ---------------- 2a: ack delayed 3 cycles, then run drops in EXEC ----------------
    do_reset();
    run_i = 1'b1; mem_rdata_i = 16'h1111;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("t2_memrd_%0d", c), 32'(mem_rd_o), 32'd1);
      check($sformatf("t2_nofault_%0d", c), 32'(fault_o), 32'd0);
    end
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    check("t2_decode", 32'(state_o), 32'd2);
    check("t2_irvalid", 32'(ir_valid_o), 32'd1);
    check("t2_ir", 32'(ir_o), 32'h1111);
    step();
    check("t2_exec", 32'(state_o), 32'd3);
    run_i = 1'b0;
    step();
    check("t5_exec_wait", 32'(state_o), 32'd3);
    exec_done_i = 1'b1;
    step();
    exec_done_i = 1'b0;
    check("t5_advance", 32'(state_o), 32'd4);
    check("t5_pcen", 32'(pc_en_o), 32'd1);
    step();
    check("t5_idle", 32'(state_o), 32'd0);
    check("t5_pcen_off", 32'(pc_en_o), 32'd0);

    // ---------------- 2b: ack on the last allowed FETCH cycle wins ----------------
    do_reset();
    run_i = 1'b1; mem_rdata_i = 16'h2222;
    for (int c = 0; c < 8; c++) step();
    check("t2b_still_fetch", 32'(state_o), 32'd1);
    mem_ack_i = 1'b1;
    step();
    check("t2b_decode", 32'(state_o), 32'd2);
    check("t2b_nofault", 32'(fault_o), 32'd0);

    // ---------------- 2c: no ack -> fault after 8 FETCH cycles ----------------
    do_reset();
    run_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("t2c_fetch_%0d", c), {31'd0, fault_o}, 32'd0);
    end
    check("t2c_last_fetch", 32'(state_o), 32'd1);
    step();
    check("t2c_fault", 32'(fault_o), 32'd1);
    check("t2c_state", 32'(state_o), 32'd6);
    mem_ack_i = 1'b1; exec_done_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      run_i = ~run_i;
      step();
      check($sformatf("t2c_sticky_%0d", c), 32'(outs()), 32'b000001);
    end

    // ---------------- 3: HALT opcode ----------------
    do_reset();
    mem_rdata_i = 16'hF000; mem_ack_i = 1'b1; exec_done_i = 1'b1; run_i = 1'b1;
    step(); step(); step();
    check("t3_halt_state", 32'(state_o), 32'd5);
    check("t3_halted", 32'(outs()), 32'b000010);
    for (int c = 0; c < 4; c++) begin
      run_i = ~run_i;
      step();
      check($sformatf("t3_sticky_%0d", c), 32'(outs()), 32'b000010);
    end
    do_reset();
    step();
    check("t3_reset_idle", 32'(state_o), 32'd0);
    check("t3_reset_outs", 32'(outs()), 32'h0);

    // ---------------- 4: branch-taken vs increment ----------------
    do_reset();
    mem_rdata_i = 16'h2345; mem_ack_i = 1'b1; exec_done_i = 1'b1; run_i = 1'b1;
    branch_taken_i = 1'b1;
    step(); step(); step(); step();
    check("t4_advance", 32'(state_o), 32'd4);
`ifdef FETCH_SEQ_BRANCH_EN
    check("t4_taken_pc", 32'({pc_en_o, pc_load_o}), 32'b01);
`else
    check("t4_taken_pc", 32'({pc_en_o, pc_load_o}), 32'b10);
`endif
    branch_taken_i = 1'b0;
    step(); step(); step(); step();
    check("t4_nt_advance", 32'(state_o), 32'd4);
    check("t4_nt_pc", 32'({pc_en_o, pc_load_o}), 32'b10);

    // ---------------- 5: reset in EXEC ----------------
    do_reset();
    mem_rdata_i = 16'h3456; mem_ack_i = 1'b1; run_i = 1'b1;
    step(); step(); step();
    check("t5r_exec", 32'(state_o), 32'd3);
    reset = 1'b1;
    step();
    check("t5r_idle", 32'(state_o), 32'd0);
    check("t5r_ir", 32'(ir_o), 32'h0);
    check("t5r_pcen", 32'(pc_en_o), 32'd0);
    reset = 1'b0; run_i = 1'b0;
    step();
    check("t5r_stay", 32'(state_o), 32'd0);
    check("t5r_pcen2", 32'(pc_en_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
